// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: a chain of STAGES valid/ready pipeline registers.
// Each register has its own stall and flush control. The chain supports
// output backpressure and bubble compaction. It also keeps two saturating
// performance counters: input-blocked cycles and squashed entries.
module pipe_stage_chain #(
  parameter int DATA_W = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  input  logic [STAGES-1:0]        stall_i,
  input  logic [STAGES-1:0]        flush_i,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*DATA_W-1:0] stage_data,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         squash_cnt
);

  localparam int PC_W = $clog2(STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [STAGES-1:0] valid_all;
  logic [DATA_W-1:0] data_all [STAGES];
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] up_valid;
  logic [DATA_W-1:0] up_data [STAGES];

  // Resolve the hold chain from the output end back toward the input.
  // A register holds only if it is occupied and it is either stalled or
  // its downstream neighbour cannot take it.
  always_comb begin
    logic rdy;
    rdy  = out_ready;
    hold = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      hold[k] = valid_all[k] & (stall_i[k] | ~rdy);
      rdy     = ~hold[k];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic              v_reg;
      logic [DATA_W-1:0] d_reg;

      // Register 0 is fed from the input port. Each later register is fed
      // from its predecessor. When the predecessor is held, its entry stays
      // put, so a bubble moves on instead of a duplicate copy.
      if (gi == 0) begin : g_head
        assign up_valid[gi] = in_valid;
        assign up_data[gi]  = in_data;
      end else begin : g_body
        assign up_valid[gi] = valid_all[gi-1] & ~hold[gi-1];
        assign up_data[gi]  = data_all[gi-1];
      end

      // Update priority is flush, then hold, then load. On a flush the
      // payload bits are left alone and only the valid bit is cleared.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          v_reg <= 1'b0;
          d_reg <= '0;
        end else if (flush_i[gi]) begin
          v_reg <= 1'b0;
        end else if (!hold[gi]) begin
          v_reg <= up_valid[gi];
          d_reg <= up_data[gi];
        end
      end

      assign valid_all[gi]                    = v_reg;
      assign data_all[gi]                     = d_reg;
      assign stage_data[gi*DATA_W +: DATA_W]  = d_reg;
    end
  endgenerate

  assign in_ready    = ~hold[0];
  assign out_valid   = valid_all[STAGES-1];
  assign out_data    = data_all[STAGES-1];
  assign stage_valid = valid_all;

  logic [PC_W-1:0]       squash_num;
  logic                  stall_inc;
  logic [CNT_W:0]        stall_sum;
  logic [CNT_W+PC_W-1:0] squash_sum;
  logic [CNT_W-1:0]      stall_cnt_reg;
  logic [CNT_W-1:0]      stall_cnt_next;
  logic [CNT_W-1:0]      squash_cnt_reg;
  logic [CNT_W-1:0]      squash_cnt_next;

  // Count the occupied entries that a flush destroys this cycle.
  always_comb begin
    squash_num = '0;
    for (int k = 0; k < STAGES; k++) begin
      squash_num = squash_num + PC_W'(flush_i[k] & valid_all[k]);
    end
  end

  assign stall_inc  = in_valid & ~in_ready;
  assign stall_sum  = {1'b0, stall_cnt_reg} + {{CNT_W{1'b0}}, stall_inc};
  assign squash_sum = {{PC_W{1'b0}}, squash_cnt_reg} + {{CNT_W{1'b0}}, squash_num};

  // Saturating counter update. A clear overrides any increment.
  always_comb begin
    stall_cnt_next  = stall_sum[CNT_W] ? CNT_MAX : stall_sum[CNT_W-1:0];
    squash_cnt_next = (squash_sum[CNT_W+PC_W-1:CNT_W] != '0) ? CNT_MAX
                                                              : squash_sum[CNT_W-1:0];
    if (cnt_clr) begin
      stall_cnt_next  = '0;
      squash_cnt_next = '0;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_reg  <= '0;
      squash_cnt_reg <= '0;
    end else begin
      stall_cnt_reg  <= stall_cnt_next;
      squash_cnt_reg <= squash_cnt_next;
    end
  end

  assign stall_cnt  = stall_cnt_reg;
  assign squash_cnt = squash_cnt_reg;

endmodule
